// File: rtl/hbm_wt_scale_unpacker_pkg.sv
// wt_unpack_pkg: FSM states, default sizes and beat-per-group math for hbm_wt_scale_unpacker.
package wt_unpack_pkg;
    typedef enum logic [1:0] {IDLE, WT, SCALE, DONE} state_t;
    localparam int DEF_HBM_DW  = 256;
    localparam int DEF_WT_DW   = 4;
    localparam int DEF_T_GROUP = 2048;
    localparam int DEF_CNT_W   = 16;
    function automatic int calc_bpg(input int hbm_dw, input int wt_dw, input int t_group);
        return t_group * wt_dw / hbm_dw;
    endfunction
endpackage

// File: rtl/hbm_wt_scale_unpacker_if.sv
// hbm_wt_scale_unpacker_if: job control, HBM input stream and the weight/scale output streams.
interface hbm_wt_scale_unpacker_if import wt_unpack_pkg::*; #(
    parameter int HBM_DW = DEF_HBM_DW,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              start;
    logic [CNT_W-1:0]  cfg_chin;
    logic [CNT_W-1:0]  cfg_rows;
    logic              busy;
    logic              done;
    logic [HBM_DW-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [HBM_DW-1:0] wt_data;
    logic              wt_valid;
    logic              wt_ready;
    logic              wt_last_grp;
    logic              wt_last_row;
    logic [HBM_DW-1:0] sc_data;
    logic              sc_valid;
    logic              sc_ready;
    logic [CNT_W-1:0]  sc_grp_idx;
    modport slave (
        input  start, cfg_chin, cfg_rows, in_data, in_valid, wt_ready, sc_ready,
        output busy, done, in_ready, wt_data, wt_valid, wt_last_grp, wt_last_row,
               sc_data, sc_valid, sc_grp_idx
    );
    modport master (
        output start, cfg_chin, cfg_rows, in_data, in_valid, wt_ready, sc_ready,
        input  busy, done, in_ready, wt_data, wt_valid, wt_last_grp, wt_last_row,
               sc_data, sc_valid, sc_grp_idx
    );
endinterface

// File: rtl/hbm_wt_scale_unpacker_seq.sv
// wt_unpack_seq: FSM plus beat/group/row counters; emits stream selects and boundary flags.
module wt_unpack_seq import wt_unpack_pkg::*; #(
    parameter int HBM_DW  = DEF_HBM_DW,
    parameter int WT_DW   = DEF_WT_DW,
    parameter int T_GROUP = DEF_T_GROUP,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_cfg_chin,
    input  logic [CNT_W-1:0] i_cfg_rows,
    input  logic             i_in_valid,
    input  logic             i_wt_ready,
    input  logic             i_sc_ready,
    input  logic             i_sc_empty,
    output logic             o_sel_wt,
    output logic             o_sel_sc,
    output logic             o_last_grp,
    output logic             o_last_row,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_grp_idx
);
    localparam int BPG = calc_bpg(HBM_DW, WT_DW, T_GROUP);
    localparam int CPB = HBM_DW / WT_DW;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_full, r_last, r_ngrp, r_rows, r_beat, r_grp, r_row;
    logic [CNT_W:0]   w_row_beats;
    logic [CNT_W-1:0] w_full, w_last;
    logic             w_partial, w_grp_end, w_row_grp, w_wt_hs, w_sc_hs;

    // Row geometry is resolved once at start so the per-beat path is compare-only.
    assign w_row_beats = ({1'b0, i_cfg_chin} + (CNT_W+1)'(CPB - 1)) / (CNT_W+1)'(CPB);
    assign w_full      = CNT_W'(w_row_beats / (CNT_W+1)'(BPG));
    assign w_last      = CNT_W'(w_row_beats % (CNT_W+1)'(BPG));

    assign w_partial = (r_last != '0) && (r_grp == r_full);
    assign w_grp_end = r_beat == (w_partial ? r_last - 1'b1 : CNT_W'(BPG - 1));
    assign w_row_grp = r_grp == r_ngrp - 1'b1;
    assign w_wt_hs   = (r_state == WT) && i_in_valid && i_wt_ready;
    assign w_sc_hs   = (r_state == SCALE) && i_in_valid && i_sc_ready;

    always_ff @(posedge clk)
        r_state <= !rst_n ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !i_start ? IDLE : (i_cfg_chin != '0 && i_cfg_rows != '0) ? WT : DONE;
            WT:      w_next = (w_wt_hs && w_grp_end) ? SCALE : WT;
            SCALE:   w_next = !w_sc_hs ? SCALE : (w_row_grp && r_row == r_rows - 1'b1) ? DONE : WT;
            default: w_next = i_sc_empty ? IDLE : DONE;
        endcase
    end

    always_comb begin
        o_sel_wt   = r_state == WT;
        o_sel_sc   = r_state == SCALE;
        o_last_grp = o_sel_wt && w_grp_end;
        o_last_row = o_last_grp && w_row_grp;
        o_done     = (r_state == DONE) && i_sc_empty;
        o_busy     = (r_state != IDLE) && !o_done;
        o_grp_idx  = r_grp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {r_full, r_last, r_ngrp, r_rows, r_beat, r_grp, r_row} <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_full <= w_full;
            r_last <= w_last;
            r_ngrp <= w_full + CNT_W'(w_last != '0);
            r_rows <= i_cfg_rows;
            r_beat <= '0;
            r_grp  <= '0;
            r_row  <= '0;
        end else if (w_wt_hs) begin
            r_beat <= r_beat + 1'b1;
        end else if (w_sc_hs) begin
            r_beat <= '0;
            r_grp  <= w_row_grp ? '0 : r_grp + 1'b1;
            r_row  <= w_row_grp ? r_row + 1'b1 : r_row;
        end
    end
endmodule

// File: rtl/hbm_wt_scale_unpacker.sv
// hbm_wt_scale_unpacker: splits an HBM weight-region beat stream into weight and scale streams.
// Define WT_SCALE_SKID_EN to buffer the scale stream in a one-entry skid register.
module hbm_wt_scale_unpacker import wt_unpack_pkg::*; #(
    parameter int HBM_DW  = DEF_HBM_DW,
    parameter int WT_DW   = DEF_WT_DW,
    parameter int T_GROUP = DEF_T_GROUP,
    parameter int CNT_W   = DEF_CNT_W
) (
    input logic                     clk,
    input logic                     rst_n,
    hbm_wt_scale_unpacker_if.slave  bus
);
    logic             w_sel_wt, w_sel_sc, w_last_grp, w_last_row, w_busy, w_done;
    logic             w_sc_rdy, w_sc_empty;
    logic [CNT_W-1:0] w_grp_idx;

    wt_unpack_seq #(
        .HBM_DW(HBM_DW), .WT_DW(WT_DW), .T_GROUP(T_GROUP), .CNT_W(CNT_W)
    ) u_seq (
        .clk(clk), .rst_n(rst_n),
        .i_start(bus.start), .i_cfg_chin(bus.cfg_chin), .i_cfg_rows(bus.cfg_rows),
        .i_in_valid(bus.in_valid), .i_wt_ready(bus.wt_ready),
        .i_sc_ready(w_sc_rdy), .i_sc_empty(w_sc_empty),
        .o_sel_wt(w_sel_wt), .o_sel_sc(w_sel_sc),
        .o_last_grp(w_last_grp), .o_last_row(w_last_row),
        .o_busy(w_busy), .o_done(w_done), .o_grp_idx(w_grp_idx)
    );

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.in_ready    = w_sel_wt ? bus.wt_ready : w_sel_sc && w_sc_rdy;
    assign bus.wt_data     = bus.in_data;
    assign bus.wt_valid    = w_sel_wt && bus.in_valid;
    assign bus.wt_last_grp = w_last_grp;
    assign bus.wt_last_row = w_last_row;

`ifdef WT_SCALE_SKID_EN
    logic              r_sk_full;
    logic [HBM_DW-1:0] r_sk_data;
    logic [CNT_W-1:0]  r_sk_grp;

    // Load and drain never coincide: a full register refuses the next scale beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sk_full <= 1'b0;
            r_sk_data <= '0;
            r_sk_grp  <= '0;
        end else if (w_sel_sc && bus.in_valid && !r_sk_full) begin
            r_sk_full <= 1'b1;
            r_sk_data <= bus.in_data;
            r_sk_grp  <= w_grp_idx;
        end else if (bus.sc_ready) begin
            r_sk_full <= 1'b0;
        end
    end

    assign w_sc_rdy       = !r_sk_full;
    assign w_sc_empty     = !r_sk_full;
    assign bus.sc_data    = r_sk_data;
    assign bus.sc_valid   = r_sk_full;
    assign bus.sc_grp_idx = r_sk_grp;
`else
    assign w_sc_rdy       = bus.sc_ready;
    assign w_sc_empty     = 1'b1;
    assign bus.sc_data    = bus.in_data;
    assign bus.sc_valid   = w_sel_sc && bus.in_valid;
    assign bus.sc_grp_idx = w_grp_idx;
`endif
endmodule

// File: tb/tb_hbm_wt_scale_unpacker.sv
// tb_hbm_wt_scale_unpacker: randomized self-checking bench against a queue-based layout model.
module tb_hbm_wt_scale_unpacker;
    localparam int HBM_DW  = 256;
    localparam int WT_DW   = 4;
    localparam int T_GROUP = 2048;
    localparam int CNT_W   = 16;
    localparam int CPB     = HBM_DW / WT_DW;
    localparam int BPG     = T_GROUP * WT_DW / HBM_DW;

    typedef struct { logic [HBM_DW-1:0] d; logic lg; logic lr; } wt_t;
    typedef struct { logic [HBM_DW-1:0] d; logic [CNT_W-1:0] g; } sc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    wt_t  exp_wt[$];
    sc_t  exp_sc[$];
    logic [HBM_DW-1:0] src[$];

    hbm_wt_scale_unpacker_if #(.HBM_DW(HBM_DW), .CNT_W(CNT_W)) bus ();

    hbm_wt_scale_unpacker #(
        .HBM_DW(HBM_DW), .WT_DW(WT_DW), .T_GROUP(T_GROUP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [HBM_DW-1:0] rand_beat();
        logic [HBM_DW-1:0] v;
        for (int i = 0; i < HBM_DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Memory layout: per row, groups of up to BPG weight beats, each followed by one scale beat.
    task automatic build_model(input int chin, input int rows);
        int  rb;
        int  n;
        wt_t w;
        sc_t c;
        exp_wt.delete();
        exp_sc.delete();
        src.delete();
        rb = (chin + CPB - 1) / CPB;
        for (int r = 0; r < rows; r++) begin
            for (int s = 0; s < rb; s += BPG) begin
                n = (rb - s < BPG) ? rb - s : BPG;
                for (int k = 0; k < n; k++) begin
                    w.d  = rand_beat();
                    w.lg = (k == n - 1);
                    w.lr = (k == n - 1) && (s + n == rb);
                    exp_wt.push_back(w);
                    src.push_back(w.d);
                end
                c.d = rand_beat();
                c.g = CNT_W'(s / BPG);
                exp_sc.push_back(c);
                src.push_back(c.d);
            end
        end
    endtask

    task automatic run_job(input string name, input int chin, input int rows, input bit rnd,
                           input int hold_sc, input int abort_at, output int total);
        int  idx = 0;
        int  cyc = 0;
        int  last_in = -1;
        int  hold = hold_sc;
        int  flow_n = 0;
        bit  fin = 1'b0;
        wt_t e;
        sc_t c;
        build_model(chin, rows);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.cfg_chin = CNT_W'(chin);
        bus.cfg_rows = CNT_W'(rows);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start got %b need 1", name, bus.busy);
        end
        while (!fin && cyc < 5000) begin
            @(negedge clk);
            bus.in_valid = (idx < src.size()) && (!rnd || $urandom_range(0, 3) != 0);
            bus.in_data  = (idx < src.size()) ? src[idx] : '0;
            bus.wt_ready = !rnd || $urandom_range(0, 3) != 0;
            bus.sc_ready = (hold == 0) && (!rnd || $urandom_range(0, 2) != 0);
            #1;
            if (bus.wt_valid && bus.wt_ready) begin
                checks++;
                if (exp_wt.size() == 0) begin
                    errors++;
                    $display("FAIL %s wt_extra got beat at cycle %0d need none", name, cyc);
                end else begin
                    e = exp_wt.pop_front();
                    if ({bus.wt_data, bus.wt_last_grp, bus.wt_last_row} !== {e.d, e.lg, e.lr}) begin
                        errors++;
                        $display("FAIL %s wt_beat got lg=%b lr=%b d=%h need lg=%b lr=%b d=%h",
                                 name, bus.wt_last_grp, bus.wt_last_row, bus.wt_data, e.lg, e.lr, e.d);
                    end
                end
                if (hold > 0 && bus.sc_valid) flow_n++;
            end
            if (bus.sc_valid && bus.sc_ready) begin
                checks++;
                if (exp_sc.size() == 0) begin
                    errors++;
                    $display("FAIL %s sc_extra got beat at cycle %0d need none", name, cyc);
                end else begin
                    c = exp_sc.pop_front();
                    if ({bus.sc_data, bus.sc_grp_idx} !== {c.d, c.g}) begin
                        errors++;
                        $display("FAIL %s sc_beat got grp=%0d d=%h need grp=%0d d=%h",
                                 name, bus.sc_grp_idx, bus.sc_data, c.g, c.d);
                    end
                end
            end
            if (hold > 0 && bus.sc_valid) begin
`ifndef WT_SCALE_SKID_EN
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s sc_stall_in_ready got %b need 0", name, bus.in_ready);
                end
`endif
                hold--;
            end
            if (bus.in_valid && bus.in_ready) begin
                idx++;
                last_in = cyc;
            end
            if (bus.done) begin
                fin = 1'b1;
                checks++;
`ifdef WT_SCALE_SKID_EN
                if (cyc <= last_in || bus.busy !== 1'b0) begin
`else
                if (cyc != last_in + 1 || bus.busy !== 1'b0) begin
`endif
                    errors++;
                    $display("FAIL %s done_timing got cycle %0d busy %b need cycle %0d busy 0",
                             name, cyc, bus.busy, last_in + 1);
                end
            end
            if (abort_at >= 0 && idx >= abort_at) fin = 1'b1;
            cyc++;
        end
        total = idx;
        if (abort_at >= 0) return;
        checks++;
        if (!fin || exp_wt.size() != 0 || exp_sc.size() != 0 || idx != src.size()) begin
            errors++;
            $display("FAIL %s completion got done=%b wt_left=%0d sc_left=%0d in=%0d need done=1 0 0 in=%0d",
                     name, fin, exp_wt.size(), exp_sc.size(), idx, src.size());
        end
`ifdef WT_SCALE_SKID_EN
        if (hold_sc > 0) begin
            checks++;
            if (flow_n == 0) begin
                errors++;
                $display("FAIL %s skid_flow got %0d wt beats during stall need >0", name, flow_n);
            end
        end
`endif
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s post_done got done=%b busy=%b need 0 0", name, bus.done, bus.busy);
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b need 0", name, bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done got %b need 0", name, bus.done); end
        checks++;
        if (bus.wt_valid !== 1'b0) begin errors++; $display("FAIL %s wt_valid got %b need 0", name, bus.wt_valid); end
        checks++;
        if (bus.sc_valid !== 1'b0) begin errors++; $display("FAIL %s sc_valid got %b need 0", name, bus.sc_valid); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready got %b need 0", name, bus.in_ready); end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = rand_beat();
        bus.wt_ready = 1'b1;
        bus.sc_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_total(input string name, input int chin, input int rows, input bit rnd,
                              input int hold_sc, input int need);
        int tot;
        run_job(name, chin, rows, rnd, hold_sc, -1, tot);
        checks++;
        if (tot !== need) begin
            errors++;
            $display("FAIL %s in_beats got %0d need %0d", name, tot, need);
        end
    endtask

    task automatic test_zero_cfg(input string name, input int chin, input int rows);
        int busy_n = 0;
        int done_n = 0;
        int rdy_n = 0;
        @(negedge clk);
        bus.cfg_chin = CNT_W'(chin);
        bus.cfg_rows = CNT_W'(rows);
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.wt_ready = 1'b1;
        bus.sc_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            busy_n += int'(bus.busy);
            done_n += int'(bus.done);
            rdy_n  += int'(bus.in_ready);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (busy_n > 1) begin errors++; $display("FAIL %s busy_cycles got %0d need <=1", name, busy_n); end
        checks++;
        if (done_n != 1) begin errors++; $display("FAIL %s done_pulses got %0d need 1", name, done_n); end
        checks++;
        if (rdy_n != 0) begin errors++; $display("FAIL %s in_ready_cycles got %0d need 0", name, rdy_n); end
    endtask

    task automatic test_reset_mid();
        int tot;
        run_job("mid_row", 512, 2, 1'b0, 0, 14, tot);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.wt_ready = 1'b1;
        bus.sc_ready = 1'b1;
        @(posedge clk);
        #1;
        check_quiet("mid_reset");
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        test_total("after_reset", 512, 2, 1'b1, 0, 18);
    endtask

    task automatic test_back_to_back();
        int tot;
        for (int i = 0; i < 4; i++)
            run_job("b2b", int'($urandom_range(1, 6000)), int'($urandom_range(1, 3)), 1'b1, 0, -1, tot);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.cfg_chin = '0;
        bus.cfg_rows = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.wt_ready = 1'b0;
        bus.sc_ready = 1'b0;
        test_reset();
        test_total("chin512", 512, 2, 1'b0, 0, 18);
        test_total("chin4096", 4096, 1, 1'b1, 0, 66);
        test_total("chin2560", 2560, 1, 1'b1, 0, 42);
        test_total("sc_stall", 512, 2, 1'b0, 5, 18);
        test_zero_cfg("rows0", 512, 0);
        test_zero_cfg("chin0", 0, 3);
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hbm_wt_scale_unpacker.md
Name: hbm_wt_scale_unpacker

Overview:
- Sits between the HBM AXI read channel and the MVM weight input.
- Consumes the raw HBM beat stream of one weight region: per CHout row, CHin weights arranged in groups of T_GROUP channels, each group's weight beats followed by exactly one scale beat.
- Splits that stream into a weight stream and a scale stream, tagged with group/row boundaries.
- Owns group and row sequencing, so the MVM never parses the memory layout.

Parameters:
- HBM_DW, 256, HBM AXI data width in bits.
- WT_DW, 4, weight width in bits.
- T_GROUP, 2048, CHin channels per scale group.
- CNT_W, 16, width of the channel, row and beat counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_*.
- cfg_chin  in  CNT_W  padded CHin per row.
- cfg_rows  in  CNT_W  CHout rows (CHout_Padding).
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse after the final scale beat is accepted.
- in_data  in  HBM_DW  HBM read data.
- in_valid  in  1  HBM read data valid.
- in_ready  out  1  HBM read data ready.
- wt_data  out  HBM_DW  weight beat.
- wt_valid  out  1  weight beat valid.
- wt_ready  in  1  weight beat ready.
- wt_last_grp  out  1  last weight beat of the current group.
- wt_last_row  out  1  last weight beat of the current row.
- sc_data  out  HBM_DW  scale beat (Tout packed scales).
- sc_valid  out  1  scale beat valid.
- sc_ready  in  1  scale beat ready.
- sc_grp_idx  out  CNT_W  group index of the scale within its row.

Behaviour:
- Beats per group and per row:
  - BPG = T_GROUP*WT_DW/HBM_DW (32 at defaults).
  - row_beats = ceil(cfg_chin*WT_DW/HBM_DW).
  - full groups = row_beats/BPG; last_beats = row_beats%BPG.
  - A partial group exists only when last_beats != 0.
  - These values are computed on start into registers; the per-beat path uses no divider.
- FSM states: IDLE, WT, SCALE, DONE.
  - IDLE: on start with cfg_chin != 0 and cfg_rows != 0, go to WT and set busy. On start with either field zero, go to DONE.
  - WT: wt_valid = in_valid; in_ready = wt_ready; sc_valid = 0. Each handshake increments beat_cnt. On the group's final beat (beat_cnt == BPG-1, or == last_beats-1 in the partial group), assert wt_last_grp combinationally with that beat and go to SCALE.
  - SCALE: sc_valid = in_valid; in_ready = sc_ready; wt_valid = 0. On handshake, grp_cnt++ and beat_cnt = 0. At end of row, grp_cnt = 0 and row_cnt++. After the last row go to DONE, otherwise return to WT.
  - DONE: pulse done for 1 cycle, clear busy, go to IDLE.
- wt_last_row is asserted together with wt_last_grp on the row's final group.
- The data path is zero-latency combinational pass-through; only control is registered.
- start while busy is ignored.
- in_valid in IDLE/DONE: in_ready = 0.
- Reset, including mid-operation: state = IDLE, all counters 0, busy/done/wt_valid/sc_valid/in_ready = 0. Pending upstream beats are the issuer's responsibility.
- When cfg_chin is a multiple of T_GROUP, the last full group carries the row-end flags and no extra scale beat is expected.

Optional Feature:
- Macro: WT_SCALE_SKID_EN.
- Defined: one-entry skid register on the scale stream.
  - In SCALE, in_ready = !skid_full, so the input is not stalled by sc_ready.
  - sc_data/sc_valid/sc_grp_idx come from the register; sc_valid is high while the register is full.
  - The FSM may return to WT while the scale is still pending.
  - A second scale beat waits (in_ready = 0) until the register drains.
  - done waits until the skid register is empty.
- Undefined: the combinational behaviour above.

Decomposition:
- Package wt_unpack_pkg: state enum, default constants (HBM_DW, WT_DW, T_GROUP), and a function computing BPG.
- Sub-module wt_unpack_seq holds the FSM and the beat/group/row counters and emits the mux selects. The top module holds the stream muxes and the optional skid register.

Test Plan:
- cfg_chin=512, cfg_rows=2 -> per row 8 wt beats (last_grp and last_row on beat 8) then 1 scale with grp_idx=0; 18 input beats total; done 1 cycle after the 18th.
- cfg_chin=4096, cfg_rows=1 -> 32 wt + 1 sc (grp 0), 32 wt + 1 sc (grp 1); last_row only on the 64th wt beat.
- cfg_chin=2560, cfg_rows=1 -> 32 wt + sc(0), 8 wt + sc(1); last_grp on wt beats 32 and 40.
- sc_ready held low 5 cycles in SCALE -> in_ready=0 and no beats lost. With WT_SCALE_SKID_EN: the scale is absorbed and the next wt beats flow immediately.
- cfg_rows=0 -> busy never observed beyond 1 cycle, done pulses, in_ready stays 0.
- rst_n low mid-row (row 1, beat 5) -> next cycle all outputs 0 and state IDLE; a new start gives a full correct sequence.
